// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge between the IF stage and an SRAM-like instruction port.
// It keeps at most one request outstanding and drops any response whose fetch was flushed.
`timescale 1ns/1ps
module inst_fetch_bridge (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_pc_i,
    input  logic        if_stall_i,
    input  logic        if_flush_i,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic        inst_req_o,
    output logic        inst_wr_o,
    output logic [1:0]  inst_size_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_DONE    = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        discard_r;
    logic        discard_nxt_s;
    logic [31:0] latch_r;
    logic [31:0] latch_nxt_s;
    logic [31:0] addr_r;
    logic [31:0] addr_nxt_s;
    logic [31:0] pc_phys_s;
    logic        pc_aligned_s;
    logic        req_s;
    logic        stallreq_s;
    logic [31:0] inst_s;

    // kseg0/kseg1 fold onto the low 512 MiB of physical space
    function automatic logic [31:0] virt_to_phys(input logic [31:0] va);
        if (va[31:30] == 2'b10) begin
            virt_to_phys = {3'b000, va[28:0]};
        end else begin
            virt_to_phys = va;
        end
    endfunction

    assign pc_phys_s    = virt_to_phys(if_pc_i);
    assign pc_aligned_s = (if_pc_i[1:0] == 2'b00);

    assign inst_wr_o   = 1'b0;
    assign inst_size_o = 2'b10;
    // A pending request keeps the address it was issued with, even if the PC moves
    assign inst_addr_o = (state_r == ST_ADDR) ? addr_r : pc_phys_s;
    assign inst_req_o  = rst_i & req_s;
    assign stallreq_o  = rst_i & stallreq_s;
    assign inst_o      = rst_i ? inst_s : 32'h0000_0000;

    // Next-state and output decode for the fetch handshake
    always_comb begin
        state_nxt_s   = state_r;
        discard_nxt_s = discard_r;
        latch_nxt_s   = latch_r;
        addr_nxt_s    = addr_r;
        req_s         = 1'b0;
        stallreq_s    = 1'b0;
        inst_s        = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (pc_aligned_s && !if_flush_i) begin
                    req_s         = 1'b1;
                    stallreq_s    = 1'b1;
                    addr_nxt_s    = pc_phys_s;
                    discard_nxt_s = 1'b0;
                    if (inst_addr_ok_i) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_ADDR;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                req_s      = 1'b1;
                stallreq_s = 1'b1;
                if (inst_addr_ok_i) begin
                    if (discard_r || if_flush_i) begin
                        state_nxt_s   = ST_DISCARD;
                        discard_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else if (if_flush_i) begin
                    discard_nxt_s = 1'b1;
                end else begin
                    discard_nxt_s = discard_r;
                end
            end
            ST_DATA: begin
                if (inst_data_ok_i) begin
                    if (if_flush_i) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        inst_s = inst_rdata_i;
                        if (if_stall_i) begin
                            state_nxt_s = ST_DONE;
                            latch_nxt_s = inst_rdata_i;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end
                end else begin
                    stallreq_s = 1'b1;
                    if (if_flush_i) begin
                        state_nxt_s   = ST_DISCARD;
                        discard_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
            end
            ST_DONE: begin
                inst_s = latch_r;
                if (!if_stall_i || if_flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DISCARD: begin
                stallreq_s = 1'b1;
                if (inst_data_ok_i) begin
                    state_nxt_s   = ST_IDLE;
                    discard_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                discard_nxt_s = 1'b0;
            end
        endcase
    end

    // State, discard flag, held instruction and pending address registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= ST_IDLE;
            discard_r <= 1'b0;
            latch_r   <= 32'h0000_0000;
            addr_r    <= 32'h0000_0000;
        end else begin
            state_r   <= state_nxt_s;
            discard_r <= discard_nxt_s;
            latch_r   <= latch_nxt_s;
            addr_r    <= addr_nxt_s;
        end
    end

endmodule

// File: doc/inst_fetch_bridge.md
INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

Interface
REQ-001 SHALL have ports clk_i in 1 (single clock) and rst_i in 1; reset is asynchronous and active-low.
REQ-002 SHALL have if_pc_i in 32 (fetch PC from IF stage), if_stall_i in 1 (IF stall from hazard unit) and if_flush_i in 1 (IF flush from hazard unit).
REQ-003 SHALL have inst_o out 32 (instruction to if2id) and stallreq_o out 1 (to hazard stallreq_from_if).
REQ-004 SHALL have inst_req_o out 1, inst_wr_o out 1, inst_size_o out 2 and inst_addr_o out 32, forming the SRAM-like request channel.
REQ-005 SHALL have inst_addr_ok_i in 1, inst_data_ok_i in 1 and inst_rdata_i in 32, forming the SRAM-like response channel.

Function
REQ-006 SHALL tie inst_wr_o=0 and inst_size_o=2'b10.
REQ-007 SHALL drive inst_addr_o as follows: if_pc_i[31:30]=2'b10 (kseg0/kseg1) -> {3'b000, if_pc_i[28:0]}; otherwise -> if_pc_i unchanged.
REQ-008 SHALL implement states IDLE, ADDR, DATA, DONE and DISCARD, plus a 1-bit discard flag.
REQ-009 IDLE, aligned PC (if_pc_i[1:0]=0), if_flush_i=0: SHALL assert inst_req_o and stallreq_o; addr_ok=1 -> DATA, else -> ADDR.
REQ-010 IDLE with a misaligned PC or with if_flush_i=1: SHALL hold inst_req_o=0, stallreq_o=0 and inst_o=0, and SHALL stay in IDLE (the AdEL exception is raised by the pipeline).
REQ-011 ADDR: SHALL hold inst_req_o=1 with a stable address until addr_ok; a request SHALL never be withdrawn.
REQ-012 ADDR: if_flush_i=1 SHALL set the discard flag.
REQ-013 ADDR on addr_ok: -> DISCARD if the flag or if_flush_i is set, else -> DATA.
REQ-014 data_ok SHALL be accepted only in DATA or DISCARD, never in the same cycle as its addr_ok; exactly one data_ok per accepted address.
REQ-015 DATA, data_ok=0: SHALL assert stallreq_o with inst_o=0; if_flush_i=1 -> DISCARD.
REQ-016 DATA, data_ok=1, no flush: SHALL make inst_o=inst_rdata_i combinationally and deassert stallreq_o.
REQ-017 Following REQ-016: if_stall_i=1 -> DONE with inst_rdata_i latched; if_stall_i=0 -> IDLE.
REQ-018 DATA, data_ok=1 with flush: SHALL drop the data, set inst_o=0 and go to IDLE.
REQ-019 DONE: SHALL hold inst_o=latched word, stallreq_o=0 and inst_req_o=0.
REQ-020 DONE: if_stall_i=0 or if_flush_i=1 -> IDLE.
REQ-021 DISCARD: SHALL hold stallreq_o=1, inst_req_o=0 and inst_o=0; on data_ok the data SHALL be dropped, the flag cleared, and the state -> IDLE.
REQ-022 SHALL have at most one outstanding request; no new request SHALL be issued in DATA, DISCARD or DONE.
REQ-023 Best-case throughput SHALL be 1 instruction per 2 cycles with addr_ok in the request cycle and data_ok on the following cycle.

Reset
REQ-024 While rst_i=0, state SHALL be IDLE, the discard flag 0, the latch 0, and inst_req_o, stallreq_o and inst_o all 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction; the memory side is reset in the same domain.
REQ-026 After reset release, the first request SHALL issue in the first cycle with an aligned PC.

Verification
REQ-027 Basic fetch: pc=0xBFC00000, addr_ok=1 in the request cycle, data_ok next cycle with rdata=0x24080001 -> inst_addr_o=0x1FC00000; stallreq_o 1 then 0; inst_o=0x24080001 in the data_ok cycle.
REQ-028 Held stall: data_ok arrives with if_stall_i=1 for 3 cycles -> DONE; inst_o stays 0x24080001 and inst_req_o=0 for those 3 cycles; IDLE on the cycle after the stall drops.
REQ-029 Flush during DATA: flush pulse one cycle before data_ok (rdata=0xDEADBEEF) -> DISCARD; 0xDEADBEEF never appears on inst_o; the next request uses the new PC 0xBFC00380.
REQ-030 Slow addr_ok: addr_ok delayed 4 cycles, flush in cycle 2 -> inst_req_o and inst_addr_o stable for 4 cycles; after addr_ok, DISCARD; the returned data is dropped.
REQ-031 Misaligned PC: pc=0xBFC00002 -> inst_req_o=0, stallreq_o=0, inst_o=0.
REQ-032 Reset: assert rst_i=0 while in DATA -> all outputs 0 immediately (asynchronously); after release, a fresh request issues for pc 0xBFC00000.
